vproc_mul_iter_block: RTL and testbench



---
 rtl/vproc_pkg.sv | 14 +
 rtl/vproc_mul_iter_step.sv | 32 +++
 rtl/vproc_mul_iter_block.sv | 121 ++++++++++++
 tb/tb_vproc_mul_iter_block.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
// Shared types and widths for the vector integer path.
// The multiplier FSM encoding lives here so the top and the bench agree on it.
package vproc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mul_iter_state_e;

   localparam int unsigned MUL_OP_W   = 33;
   localparam int unsigned MUL_PROD_W = 66;

endpackage

// File: rtl/vproc_mul_iter_step.sv
// One iteration of the shift-add multiplier: folds STEP_W multiplier bits into the accumulator.
// The top bit of the final step carries weight -2^32, so its partial product is subtracted.
module vproc_mul_iter_step
   import vproc_pkg::*;
#(
   parameter int unsigned STEP_W = 1
) (
   input  logic [MUL_PROD_W-1:0] acc_i,
   input  logic [MUL_PROD_W-1:0] mcand_i,
   input  logic [STEP_W-1:0]     bits_i,
   input  logic                  last_i,
   output logic [MUL_PROD_W-1:0] acc_o
);

   always_comb begin : sum_blk
      logic [MUL_PROD_W-1:0] sum;
      logic [MUL_PROD_W-1:0] pp;
      // NOTE: blocking assignments here build a ripple of adders inside one combinational cycle.
      sum = acc_i;
      pp  = '0;
      for (int i = 0; i < int'(STEP_W); i++) begin
         pp = bits_i[i] ? (mcand_i << i) : '0;
         if (last_i && (i == int'(STEP_W) - 1)) begin
            sum = sum - pp;
         end else begin
            sum = sum + pp;
         end
      end
      acc_o = sum;
   end

endmodule

// File: rtl/vproc_mul_iter_block.sv
// Iterative 33x33 signed/unsigned multiplier with valid/ready on both sides.
// Returns the low or high word of the 66-bit two's-complement product.
module vproc_mul_iter_block
   import vproc_pkg::*;
#(
   parameter int unsigned STEP_W    = 1,
   parameter bit          ZERO_SKIP = 1'b1
) (
   input  logic                clk_i,
   input  logic                sync_rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [MUL_OP_W-1:0] op1_i,
   input  logic [MUL_OP_W-1:0] op2_i,
   input  logic                high_i,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [31:0]         res_o
);

   if (!(STEP_W == 1 || STEP_W == 3 || STEP_W == 11)) begin : g_bad_step_w
      $error("vproc_mul_iter_block: STEP_W must be 1, 3 or 11");
   end

   localparam int unsigned STEPS = MUL_OP_W / STEP_W;
   localparam int unsigned CNT_W = $clog2(STEPS + 1);

   mul_iter_state_e       state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [MUL_PROD_W-1:0] acc_q, acc_d;
   logic [MUL_PROD_W-1:0] mcand_q, mcand_d;
   logic [MUL_OP_W-1:0]   mplier_q, mplier_d;
   logic                  high_q, high_d;
   logic [31:0]           res_q, res_d;

   logic [MUL_PROD_W-1:0] acc_step;
   logic                  last_step;
   logic                  accept;

   assign last_step   = (cnt_q == CNT_W'(1));
   assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && res_ready_i);
   assign accept      = in_valid_i && in_ready_o;
   assign res_valid_o = (state_q == DONE);
   assign res_o       = res_q;

   vproc_mul_iter_step #(
      .STEP_W (STEP_W)
   ) u_step (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .bits_i  (mplier_q[STEP_W-1:0]),
      .last_i  (last_step),
      .acc_o   (acc_step)
   );

   always_comb begin
      // NOTE: every _d starts as its _q so no path leaves a signal unassigned (no latches).
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      high_d   = high_q;
      res_d    = res_q;

      unique case (state_q)
         BUSY: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << STEP_W;
            mplier_d = mplier_q >> STEP_W;
            cnt_d    = cnt_q - CNT_W'(1);
            if (last_step) begin
               state_d = DONE;
               res_d   = high_q ? acc_step[63:32] : acc_step[31:0];
            end
         end
         DONE: begin
            if (res_ready_i) begin
               state_d = IDLE;
            end
         end
         default: ;
      endcase

      // Operands are only captured on a real handshake, so idle X never reaches state.
      if (accept) begin
         mcand_d  = {{(MUL_PROD_W - MUL_OP_W){op1_i[MUL_OP_W-1]}}, op1_i};
         mplier_d = op2_i;
         high_d   = high_i;
         acc_d    = '0;
         cnt_d    = CNT_W'(STEPS);
         state_d  = BUSY;
         if (ZERO_SKIP && ((op1_i == '0) || (op2_i == '0))) begin
            state_d = DONE;
            res_d   = '0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         high_q   <= 1'b0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         high_q   <= high_d;
         res_q    <= res_d;
      end
   end

endmodule

// File: tb/tb_vproc_mul_iter_block.sv
// Directed bench for the iterative multiplier at STEP_W = 1, 3 and 11.
// Instance 0 (STEP_W=1) takes the directed vectors; all three take a random sweep.
module tb_vproc_mul_iter_block;

   logic        clk = 1'b0;
   logic        rst;
   logic [32:0] op1;
   logic [32:0] op2;
   logic        high;
   logic        in_valid  [3];
   logic        res_ready [3];
   logic        in_ready  [3];
   logic        res_valid [3];
   logic [31:0] res       [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      vproc_mul_iter_block #(
         .STEP_W    ((g == 0) ? 1 : ((g == 1) ? 3 : 11)),
         .ZERO_SKIP (1'b1)
      ) u_dut (
         .clk_i       (clk),
         .sync_rst_i  (rst),
         .in_valid_i  (in_valid[g]),
         .in_ready_o  (in_ready[g]),
         .op1_i       (op1),
         .op2_i       (op2),
         .high_i      (high),
         .res_valid_o (res_valid[g]),
         .res_ready_i (res_ready[g]),
         .res_o       (res[g])
      );
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [65:0] ref_prod(input logic [32:0] a, input logic [32:0] b);
      logic signed [65:0] sa;
      logic signed [65:0] sb;
      sa = {{33{a[32]}}, a};
      sb = {{33{b[32]}}, b};
      return sa * sb;
   endfunction

   function automatic logic [32:0] rand_op();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 4))
         0:       return {1'b0, w};
         1:       return {w[31], w};
         2:       return 33'd0;
         3:       return {1'b1, w};
         default: return {1'b0, 16'h0000, w[15:0]};
      endcase
   endfunction

   // Issue one request from IDLE and collect its result; lat is the cycle of res_valid relative to the accept cycle.
   task automatic run_op(input int k, input logic [32:0] a, input logic [32:0] b, input logic h,
                         output logic [31:0] r, output int lat);
      op1         = a;
      op2         = b;
      high        = h;
      in_valid[k] = 1'b1;
      lat         = 0;
      tick();
      lat++;
      in_valid[k] = 1'b0;
      while (!res_valid[k] && lat < 200) begin
         tick();
         lat++;
      end
      if (!res_valid[k]) check($sformatf("timeout_inst%0d", k), 64'(res_valid[k]), 64'd1);
      r = res[k];
      tick();
   endtask

   initial begin
      logic [31:0] r;
      logic [65:0] p;
      logic [32:0] a;
      logic [32:0] b;
      logic        h;
      int          lat;
      int          exp_lat;
      int          seen;

      rst  = 1'b1;
      op1  = '0;
      op2  = '0;
      high = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid[k]  = 1'b0;
         res_ready[k] = 1'b1;
      end
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_in_ready%0d", k), 64'(in_ready[k]), 64'd1);
         check($sformatf("rst_res_valid%0d", k), 64'(res_valid[k]), 64'd0);
         check($sformatf("rst_res%0d", k), 64'(res[k]), 64'd0);
      end
      rst = 1'b0;
      tick();

      run_op(0, 33'h0_00000007, 33'h0_00000006, 1'b0, r, lat);
      check("basic_res", 64'(r), 64'h2A);
      check("basic_lat", 64'(lat), 64'd34);

      run_op(0, 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 1'b1, r, lat);
      check("unsigned_high", 64'(r), 64'hFFFFFFFE);
      run_op(0, 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 1'b0, r, lat);
      check("unsigned_low", 64'(r), 64'h00000001);

      run_op(0, 33'h1_FFFFFFFF, 33'h1_FFFFFFFF, 1'b0, r, lat);
      check("neg1_sq_low", 64'(r), 64'h00000001);
      run_op(0, 33'h1_FFFFFFFF, 33'h1_FFFFFFFF, 1'b1, r, lat);
      check("neg1_sq_high", 64'(r), 64'h00000000);
      run_op(0, 33'h1_FFFFFFFE, 33'h0_FFFFFFFF, 1'b1, r, lat);
      check("mixed_high", 64'(r), 64'hFFFFFFFE);
      run_op(0, 33'h1_FFFFFFFE, 33'h0_FFFFFFFF, 1'b0, r, lat);
      check("mixed_low", 64'(r), 64'h00000002);

      run_op(0, 33'h0_12345678, 33'h0_00000000, 1'b1, r, lat);
      check("zero_op2_res", 64'(r), 64'd0);
      check("zero_op2_lat", 64'(lat), 64'd1);
      run_op(0, 33'h0_00000000, 33'h1_FFFFFFFF, 1'b0, r, lat);
      check("zero_op1_res", 64'(r), 64'd0);
      check("zero_op1_lat", 64'(lat), 64'd1);

      // Back-to-back: zero-shortcut result handed off in the same cycle the next request is taken.
      op1         = 33'd5;
      op2         = 33'd0;
      high        = 1'b0;
      in_valid[0] = 1'b1;
      tick();
      op1 = 33'd3;
      op2 = 33'd5;
      check("b2b_first_valid", 64'(res_valid[0]), 64'd1);
      check("b2b_first_res", 64'(res[0]), 64'd0);
      check("b2b_in_ready", 64'(in_ready[0]), 64'd1);
      tick();
      in_valid[0] = 1'b0;
      check("b2b_accepted", 64'(in_ready[0]), 64'd0);
      check("b2b_valid_drop", 64'(res_valid[0]), 64'd0);
      lat = 1;
      while (!res_valid[0] && lat < 100) begin
         tick();
         lat++;
      end
      check("b2b_second_lat", 64'(lat), 64'd34);
      check("b2b_second_res", 64'(res[0]), 64'hF);
      tick();

      // Backpressure: result must hold and stray requests must be ignored.
      res_ready[0] = 1'b0;
      op1          = 33'd9;
      op2          = 33'd9;
      high         = 1'b0;
      in_valid[0]  = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      lat = 1;
      while (!res_valid[0] && lat < 100) begin
         tick();
         lat++;
      end
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_valid%0d", i), 64'(res_valid[0]), 64'd1);
         check($sformatf("bp_res%0d", i), 64'(res[0]), 64'h51);
         check($sformatf("bp_in_ready%0d", i), 64'(in_ready[0]), 64'd0);
         in_valid[0] = (i % 2 == 0);
         op1         = 33'd2;
         op2         = 33'd2;
         tick();
      end
      in_valid[0] = 1'b0;
      check("bp_hold_res", 64'(res[0]), 64'h51);
      res_ready[0] = 1'b1;
      tick();
      check("bp_release_valid", 64'(res_valid[0]), 64'd0);
      check("bp_release_ready", 64'(in_ready[0]), 64'd1);
      tick();
      check("bp_single_xfer", 64'(res_valid[0]), 64'd0);

      // Reset in the middle of a computation.
      op1         = 33'h0_00012345;
      op2         = 33'h0_00000010;
      high        = 1'b0;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", 64'(res_valid[0]), 64'd0);
      check("midrst_ready", 64'(in_ready[0]), 64'd1);
      seen = 0;
      repeat (40) begin
         tick();
         if (res_valid[0]) seen = 1;
      end
      check("midrst_no_spurious", 64'(seen), 64'd0);
      run_op(0, 33'd100, 33'd200, 1'b0, r, lat);
      check("midrst_fresh_res", 64'(r), 64'h4E20);
      check("midrst_fresh_lat", 64'(lat), 64'd34);

      // Random sweep on each STEP_W, against a 66-bit signed reference product.
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 1000; n++) begin
            a = rand_op();
            b = rand_op();
            h = 1'($urandom_range(0, 1));
            p = ref_prod(a, b);
            exp_lat = ((a == '0) || (b == '0)) ? 1 : (33 / ((k == 0) ? 1 : ((k == 1) ? 3 : 11)) + 1);
            run_op(k, a, b, h, r, lat);
            check($sformatf("sweep%0d_res a=%h b=%h h=%0d", k, a, b, h), 64'(r),
                  64'(h ? p[63:32] : p[31:0]));
            check($sformatf("sweep%0d_lat", k), 64'(lat), 64'(exp_lat));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
